// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    PCTRL_RUN        = 3'd0,
    PCTRL_DRAIN      = 3'd1,
    PCTRL_HALTED     = 3'd2,
    PCTRL_STEP_FETCH = 3'd3,
    PCTRL_STEP_WAIT  = 3'd4
  } pctrl_state_t;

  localparam logic [5:0] OPCODE_HALT = 6'h3f;
  localparam int         REG_W       = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline stages and the stall/flush enables returned to them.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             branch_mispredict;
  logic             id_halt;
  logic             wb_halt;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           branch_mispredict, id_halt, wb_halt,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           branch_mispredict, id_halt, wb_halt,
    output pc_write, if_id_write, if_id_flush, id_ex_flush
  );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use interlock detect: a load in EX whose destination feeds the instruction in ID.
// Purely combinational, zero latency; $0 never interlocks.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             lu
);

  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: Mealy hazard enables (zero latency) plus registered debug halt/step FSM.
// Arbitration order in RUN is mispredict > load-use > halt; counters saturate at all-ones.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_ctrl_if.slave       pipe,
  input  logic                 dbg_run_req,
  input  logic                 dbg_step_req,
  output logic                 halted,
  output logic                 step_done,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  localparam int                STEP_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(DRAIN_CYCLES - 1);

  pctrl_state_t      state;
  logic [STEP_W-1:0] step_cnt;
  logic              lu;
  logic              pc_write, if_id_write, if_id_flush, id_ex_flush;

  load_use_detect u_lu (
    .ex_mem_read (pipe.ex_mem_read),
    .ex_rt       (pipe.ex_rt),
    .id_rs       (pipe.id_rs),
    .id_rt       (pipe.id_rt),
    .id_uses_rs  (pipe.id_uses_rs),
    .id_uses_rt  (pipe.id_uses_rt),
    .lu          (lu)
  );

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state)
      PCTRL_RUN: begin
        if (pipe.branch_mispredict) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (pipe.id_halt) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
        end
      end
      PCTRL_DRAIN: begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      PCTRL_HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      PCTRL_STEP_FETCH: id_ex_flush = 1'b1;
      PCTRL_STEP_WAIT: begin
        // A mispredict resolved by the stepped instruction must still land in the PC.
        pc_write    = pipe.branch_mispredict;
        if_id_flush = 1'b1;
        id_ex_flush = (step_cnt != STEP_LOAD);
      end
      default: ;
    endcase
  end

  assign pipe.pc_write    = pc_write;
  assign pipe.if_id_write = if_id_write;
  assign pipe.if_id_flush = if_id_flush;
  assign pipe.id_ex_flush = id_ex_flush;
  assign halted           = (state == PCTRL_HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PCTRL_RUN;
      step_cnt     <= '0;
      step_done    <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      step_done <= 1'b0;
      case (state)
        PCTRL_RUN: begin
          if (pipe.branch_mispredict) begin
            if (flush_events != '1) flush_events <= flush_events + 1'b1;
          end else if (lu) begin
            if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
          end else if (pipe.id_halt) begin
            state <= PCTRL_DRAIN;
          end
        end
        PCTRL_DRAIN:
          if (pipe.wb_halt) state <= PCTRL_HALTED;
        PCTRL_HALTED:
          if (dbg_step_req)     state <= PCTRL_STEP_FETCH;
          else if (dbg_run_req) state <= PCTRL_RUN;
        PCTRL_STEP_FETCH: begin
          step_cnt <= STEP_LOAD;
          state    <= PCTRL_STEP_WAIT;
        end
        PCTRL_STEP_WAIT: begin
          if (step_cnt == '0) begin
            step_done <= 1'b1;
            state     <= PCTRL_HALTED;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
        default: state <= PCTRL_RUN;
      endcase
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the PC write enable, the IF/ID write and flush controls, and the ID/EX `flush` input. It arbitrates between load-use interlocks, branch-mispredict recovery and the debug halt/step protocol. Hazard responses are combinational (Mealy) so they act in the same cycle they are detected. Debug sequencing runs on a registered FSM.

## Interface
- `CNT_WIDTH`, 32, width of the performance counters.
- `DRAIN_CYCLES`, 4, cycles for one fetched instruction to leave ID through WB.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction in ID reads that operand
- `ex_mem_read`  in  1  instruction in EX is a load (ID/EX `mem_read_out`)
- `ex_rt`  in  5  load destination (ID/EX `rt_out`)
- `branch_mispredict`  in  1  EX resolved a mispredicted branch/jump
- `id_halt`  in  1  HALT opcode decoded in ID
- `wb_halt`  in  1  HALT has reached WB
- `dbg_run_req`, `dbg_step_req`  in  1 each  debug-unit commands, level, sampled only in HALTED
- `pc_write`  out  1  PC register load enable
- `if_id_write`  out  1  IF/ID load enable
- `if_id_flush`  out  1  IF/ID loads a NOP
- `id_ex_flush`  out  1  ID/EX loads a NOP (drives latch `flush`)
- `halted`  out  1  FSM in HALTED
- `step_done`  out  1  one-cycle pulse when a step completes
- `stall_cycles`, `flush_events`  out  CNT_WIDTH each  saturating performance counters

## Operation
- FSM states: RUN, DRAIN, HALTED, STEP_FETCH, STEP_WAIT.
- Load-use hazard (`lu`) = `ex_mem_read` & `ex_rt`≠0 & ((`id_uses_rs` & `id_rs`==`ex_rt`) | (`id_uses_rt` & `id_rt`==`ex_rt`)).
- RUN, in priority order:
  - `branch_mispredict`: `pc_write`=1, `if_id_flush`=1, `id_ex_flush`=1, `flush_events`++. A same-cycle `id_halt` is wrong-path and is ignored. Stay in RUN.
  - Else `lu`: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `stall_cycles`++.
  - Else `id_halt`: `pc_write`=0, `if_id_flush`=1. HALT passes into ID/EX. Go to DRAIN.
  - Else all enables=1, all flushes=0.
- DRAIN: `pc_write`=0, `if_id_flush`=1, `id_ex_flush`=1. Go to HALTED on `wb_halt`. PC stays frozen at HALT+4.
- HALTED: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `halted`=1.
  - `dbg_step_req` goes to STEP_FETCH.
  - Else `dbg_run_req` goes to RUN.
  - Step wins if both are asserted.
- STEP_FETCH, one cycle: `pc_write`=1, `if_id_write`=1, `id_ex_flush`=1. Load the step counter with DRAIN_CYCLES−1. Go to STEP_WAIT.
- STEP_WAIT:
  - `pc_write`=0, `if_id_flush`=1. `id_ex_flush`=0 on the first cycle only, so the stepped instruction enters EX.
  - Counter decrements each cycle. At 0, pulse `step_done` and return to HALTED.
  - `branch_mispredict` here forces `pc_write`=1 so the corrected target is captured; it is not counted.
- Counters saturate at all-ones. No wrap.
- Reset value of every output: counters 0, `step_done` 0, state RUN. This gives `pc_write`=1, `if_id_write`=1, both flushes 0, `halted`=0.
- Reset mid-step or mid-drain returns to RUN immediately. A pending step is abandoned and no `step_done` is issued.

## Timing
- Hazard outputs are combinational from the current state and inputs. Zero-cycle latency.
- State, step counter, performance counters and `step_done` are registered on `clk`.
- A load-use stall lasts exactly 1 cycle: the next cycle the load is in MEM, so `lu`=0.
- `halted` rises the cycle after `wb_halt`.
- Step latency: `dbg_step_req` sampled, then 1 cycle STEP_FETCH plus DRAIN_CYCLES cycles STEP_WAIT, then `step_done`.

## Structure
- Add to `mips_pkg.vh`: state encodings `PCTRL_RUN`, `PCTRL_DRAIN`, `PCTRL_HALTED`, `PCTRL_STEP_FETCH`, `PCTRL_STEP_WAIT` (3 bits), and `OPCODE_HALT`.
- Sub-module `load_use_detect`: purely combinational, computes `lu`.
- The FSM, counters and output muxing live in `pipeline_ctrl`.

## Test plan
- Load-use: `lw $2,0($1)` then `add $3,$2,$4`.
  - Expected: exactly one cycle with `pc_write`=0 and `id_ex_flush`=1, then `stall_cycles`=1.
  - Repeat with `ex_rt`=0: no stall.
- Mispredict plus simultaneous `lu` and `id_halt`: all three asserted in one cycle.
  - Expected: flush-only response, state stays RUN, `flush_events`=1, `stall_cycles` unchanged.
- Halt: HALT at 0x40.
  - Expected: DRAIN, then `wb_halt`, then `halted`=1 next cycle with PC=0x44.
  - `dbg_run_req` then resumes fetch at 0x44.
- Step from HALTED: `dbg_step_req`.
  - Expected: one `pc_write` pulse, `step_done` 5 cycles later, `halted` stays high afterwards, PC advanced by 4.
- Reset during STEP_WAIT (counter=2).
  - Expected: next cycle state RUN, counters 0, no `step_done`.
- Saturation: preload `stall_cycles` to all-ones via a `CNT_WIDTH`=4 build, then apply 3 more stalls.
  - Expected: value remains 4'hF.
